// File: rtl/camera_ray_generator.sv
// camera_ray_generator: emits one primary ray per pixel in raster order on a valid/ready stream.
// Direction is tracked incrementally as (FOCAL, x - H_RES/2, V_RES/2 - y).
module camera_ray_generator #(
  parameter int H_RES = 64,
  parameter int V_RES = 48,
  parameter int FOCAL = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0][11:0] camera_location_in,
  input  logic             ray_ready,
  output logic             ray_valid,
  output logic [2:0][11:0] camera_location,
  output logic [2:0][11:0] directional_vector,
  output logic [11:0]      pixel_x,
  output logic [11:0]      pixel_y,
  output logic             last_ray,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
  localparam logic [11:0] X_MAX = 12'(H_RES - 1);
  localparam logic [11:0] Y_MAX = 12'(V_RES - 1);
  localparam logic [11:0] DX = 12'(FOCAL);
  localparam logic [11:0] DY0 = 12'(-(H_RES / 2));
  localparam logic [11:0] DZ0 = 12'(V_RES / 2);
  state_t r_state;
  logic   w_hs;
  assign w_hs = ray_valid && ray_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      ray_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      last_ray <= 1'b0;
      pixel_x <= '0;
      pixel_y <= '0;
      camera_location <= '0;
      directional_vector <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            camera_location <= camera_location_in;
            pixel_x <= '0;
            pixel_y <= '0;
            directional_vector <= {DZ0, DY0, DX};
            ray_valid <= 1'b1;
            busy <= 1'b1;
            last_ray <= 1'b0;
            r_state <= EMIT;
          end
        end
        EMIT: begin
          if (w_hs) begin
            // last_ray is registered one step ahead, so it doubles as the end-of-frame flag
            if (last_ray) begin
              ray_valid <= 1'b0;
              last_ray <= 1'b0;
              done <= 1'b1;
              r_state <= DONE;
            end else if (pixel_x != X_MAX) begin
              pixel_x <= pixel_x + 12'd1;
              directional_vector[1] <= directional_vector[1] + 12'd1;
              last_ray <= (pixel_y == Y_MAX) && (pixel_x == X_MAX - 12'd1);
            end else begin
              pixel_x <= '0;
              pixel_y <= pixel_y + 12'd1;
              directional_vector[1] <= DY0;
              directional_vector[2] <= directional_vector[2] - 12'd1;
            end
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/camera_ray_generator.md
# camera_ray_generator

Produces one primary ray per screen pixel for the ray-casting path. Each ray is a camera location plus a 12-bit directional vector. Rays are emitted in raster order on a valid/ready stream, and that stream feeds the face/vector intersection stage directly. Direction components are generated incrementally, with no multiplier or divider. The x component is held at a non-zero constant so the downstream divisions by `directional_vector[0]` are always defined.

## Interface
Parameters:
- `H_RES`, default 64: pixels per row; must be even, 2..2048.
- `V_RES`, default 48: rows per frame; must be even, 2..2048.
- `FOCAL`, default 64: x component of every ray; 1..2047.

Ports:
- `clk`  in  1: the single clock. All logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: frame request. Sampled only in IDLE.
- `camera_location_in`  in  [2:0][11:0]: camera position. Latched on an accepted `start`.
- `ray_ready`  in  1: downstream accepts the current ray.
- `ray_valid`  out  1: `camera_location`, `directional_vector`, `pixel_x`, `pixel_y` and `last_ray` are valid.
- `camera_location`  out  [2:0][11:0]: latched camera position.
- `directional_vector`  out  [2:0][11:0]: ray direction; components 1 and 2 are two's complement.
- `pixel_x`  out  12: column, 0..H_RES-1.
- `pixel_y`  out  12: row, 0..V_RES-1, with 0 as the top row.
- `last_ray`  out  1: high together with the final ray of the frame.
- `busy`  out  1: high when the state is not IDLE.
- `done`  out  1: one-cycle pulse after the final handshake.

## Operation
- The FSM has three states: IDLE, EMIT and DONE.
- IDLE:
  - `ray_valid`, `busy` and `done` are 0.
  - When `start` is high:
    - Latch `camera_location_in`.
    - Set `pixel_x`=0 and `pixel_y`=0.
    - Set `directional_vector`=(FOCAL, -H_RES/2, V_RES/2).
    - Go to EMIT.
- EMIT:
  - `ray_valid`=1.
  - A handshake is a cycle where `ray_valid && ray_ready`.
  - On a handshake that is not the last ray, advance the position:
    - If `pixel_x`<H_RES-1: `pixel_x`+1 and `directional_vector[1]`+1.
    - Otherwise: `pixel_x`=0, `directional_vector[1]`=-H_RES/2, `pixel_y`+1, and `directional_vector[2]`-1.
  - On the handshake of the last ray, go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. `ray_valid` is 0 in this state.
- The direction is always (FOCAL, pixel_x - H_RES/2, V_RES/2 - pixel_y), computed modulo 2^12. Running registers must match this closed form on every cycle.
- `last_ray` = (`pixel_x`==H_RES-1 && `pixel_y`==V_RES-1 && `ray_valid`).
- `start` is ignored in EMIT and DONE; it is neither queued nor does it restart the frame.
- A `camera_location_in` change during a frame has no effect on that frame.
- `directional_vector[0]` never changes and is never 0.

## Timing
- All outputs are registered.
- Reset values: `ray_valid`=0, `busy`=0, `done`=0, `last_ray`=0, `pixel_x`=0, `pixel_y`=0, `camera_location`=0, `directional_vector`=0. State is IDLE.
- Latency: with `start` sampled at edge N, `ray_valid` and `busy` are 1 from edge N+1.
- Throughput is one ray per cycle while `ray_ready` is held at 1.
- With `ray_ready` held at 1:
  - The last handshake occurs at cycle N+H_RES*V_RES.
  - `done` is high in cycle N+H_RES*V_RES+1.
  - `busy` falls at N+H_RES*V_RES+2.
- Backpressure: while `ray_valid` && !`ray_ready`, all payload outputs and `last_ray` hold stable. `ray_valid` never drops before its handshake.
- `ray_valid` must not depend combinationally on `ray_ready`.
- A `start` arriving in the same cycle as the DONE pulse is ignored.
- A `start` sampled in the cycle after DONE (IDLE) is accepted.
- Reset mid-frame: on the next edge all outputs take their reset values. No `done` pulse is produced. The partial frame is abandoned.
- Reset has priority over `start` when both are asserted.

## Test plan
- H_RES=4, V_RES=2, FOCAL=8, camera=(100,5,7), `ray_ready`=1.
  - Required: 8 rays.
  - `directional_vector` y,z sequence is (-2,1), (-1,1), (0,1), (1,1), (-2,0), (-1,0), (0,0), (1,0), each with x=8.
  - Camera is (100,5,7) on every ray.
  - `last_ray` is high only on the 8th ray.
  - `done` rises 1 cycle after the 8th handshake.
- Same configuration, with `ray_ready` toggled 1,0,0,1 repeating.
  - Required: the identical ray sequence.
  - Payload is stable across stalled cycles.
  - Each ray is accepted exactly once.
- Issue `start` again at the 3rd ray with `camera_location_in`=(0,0,0).
  - Required: the frame continues with camera (100,5,7).
  - Exactly 8 rays and one `done`.
- Assert `reset` for 1 cycle after the 5th handshake.
  - Required: `ray_valid`=0, `busy`=0 and `directional_vector`=0 on the next cycle.
  - No `done` pulse.
  - A new `start` restarts the frame from (-2,1).
- Default parameters (64×48, FOCAL 64) with `ray_ready`=1.
  - Required: the first ray direction is (64,-32,24).
  - The ray at pixel (63,47) is (64,31,-23) = 12'hFE9 in z.
  - The frame totals 3072 rays.
  - `done` occurs at start+3073.
